// File: rtl/ddr3_cmd_arbiter.sv
// Two-master arbiter for the DDR3 user interface, with a FIFO tracking which master owns each outstanding read.
// Define ARB_M0_PRIORITY_EN for strict m0 priority; the default build is round-robin.
module ddr3_cmd_arbiter #(
   parameter int ADDR_WIDTH    = 28,
   parameter int DATA_WIDTH    = 128,
   parameter int RD_FIFO_DEPTH = 4
) (
   input  logic                    dma_clk,
   input  logic                    ddr_rst,
   input  logic                    init_calib_complete,
   // master 0
   input  logic                    m0_cmd_en,
   input  logic [2:0]              m0_cmd,
   input  logic [ADDR_WIDTH-1:0]   m0_addr,
   input  logic [5:0]              m0_app_burst_number,
   output logic                    m0_cmd_ready,
   input  logic                    m0_wr_data_en,
   input  logic                    m0_wr_data_end,
   input  logic [DATA_WIDTH-1:0]   m0_wr_data,
   input  logic [DATA_WIDTH/8-1:0] m0_wr_data_mask,
   output logic                    m0_wr_data_rdy,
   output logic                    m0_rd_data_valid,
   output logic                    m0_rd_data_end,
   output logic [DATA_WIDTH-1:0]   m0_rd_data,
   // master 1
   input  logic                    m1_cmd_en,
   input  logic [2:0]              m1_cmd,
   input  logic [ADDR_WIDTH-1:0]   m1_addr,
   input  logic [5:0]              m1_app_burst_number,
   output logic                    m1_cmd_ready,
   input  logic                    m1_wr_data_en,
   input  logic                    m1_wr_data_end,
   input  logic [DATA_WIDTH-1:0]   m1_wr_data,
   input  logic [DATA_WIDTH/8-1:0] m1_wr_data_mask,
   output logic                    m1_wr_data_rdy,
   output logic                    m1_rd_data_valid,
   output logic                    m1_rd_data_end,
   output logic [DATA_WIDTH-1:0]   m1_rd_data,
   // DDR3 user side
   input  logic                    cmd_ready,
   input  logic                    wr_data_rdy,
   input  logic                    rd_data_valid,
   input  logic                    rd_data_end,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    cmd_en,
   output logic [2:0]              cmd,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic [5:0]              app_burst_number,
   output logic                    wr_data_en,
   output logic                    wr_data_end,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_data_mask,
   output logic                    err_rd_orphan
);

   localparam int PW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
   localparam int CW = $clog2(RD_FIFO_DEPTH + 1);
   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA} state_t;

   state_t         state_q, state_d;
   logic           gnt_q, gnt_d;
`ifndef ARB_M0_PRIORITY_EN
   logic           last_q, last_d;
`endif
   logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           own_q [RD_FIFO_DEPTH];
   logic           err_q, err_d;
   logic           push, pop, full, empty, elig0, elig1, pick, head;
   logic           sel_en;
   logic [2:0]     sel_cmd;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(RD_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt_q == CW'(RD_FIFO_DEPTH));
   assign empty   = (cnt_q == '0);
   assign head    = own_q[rp_q];
   assign elig0   = m0_cmd_en && ((m0_cmd != CMD_RD) || !full);
   assign elig1   = m1_cmd_en && ((m1_cmd != CMD_RD) || !full);
   assign sel_en  = gnt_q ? m1_cmd_en : m0_cmd_en;
   assign sel_cmd = gnt_q ? m1_cmd : m0_cmd;
`ifdef ARB_M0_PRIORITY_EN
   assign pick = !elig0;
`else
   // on a tie the master that did not win last time goes next
   assign pick = (elig0 && elig1) ? !last_q : !elig0;
`endif

   always_comb begin
      state_d          = state_q;
      gnt_d            = gnt_q;
`ifndef ARB_M0_PRIORITY_EN
      last_d           = last_q;
`endif
      err_d            = err_q;
      push             = 1'b0;
      pop              = 1'b0;
      m0_cmd_ready     = 1'b0;
      m1_cmd_ready     = 1'b0;
      m0_wr_data_rdy   = 1'b0;
      m1_wr_data_rdy   = 1'b0;
      m0_rd_data_valid = 1'b0;
      m1_rd_data_valid = 1'b0;
      m0_rd_data_end   = 1'b0;
      m1_rd_data_end   = 1'b0;
      m0_rd_data       = '0;
      m1_rd_data       = '0;
      cmd_en           = 1'b0;
      cmd              = '0;
      addr             = '0;
      app_burst_number = '0;
      wr_data_en       = 1'b0;
      wr_data_end      = 1'b0;
      wr_data          = '0;
      wr_data_mask     = '0;
      err_rd_orphan    = 1'b0;
      if (!ddr_rst) begin
         m0_rd_data    = rd_data;
         m1_rd_data    = rd_data;
         err_rd_orphan = err_q;
         case (state_q)
            S_IDLE: begin
               if (init_calib_complete && (elig0 || elig1)) begin
                  gnt_d   = pick;
`ifndef ARB_M0_PRIORITY_EN
                  last_d  = pick;
`endif
                  state_d = S_CMD;
               end
            end
            S_CMD: begin
               cmd_en           = sel_en;
               cmd              = sel_cmd;
               addr             = gnt_q ? m1_addr : m0_addr;
               app_burst_number = gnt_q ? m1_app_burst_number : m0_app_burst_number;
               if (gnt_q) m1_cmd_ready = cmd_ready;
               else       m0_cmd_ready = cmd_ready;
               if (sel_en && cmd_ready) begin
                  if (sel_cmd == CMD_RD) begin
                     push    = 1'b1;
                     state_d = S_IDLE;
                  end else if (sel_cmd == CMD_WR) begin
                     state_d = S_WDATA;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_WDATA: begin
               wr_data_en   = gnt_q ? m1_wr_data_en   : m0_wr_data_en;
               wr_data_end  = gnt_q ? m1_wr_data_end  : m0_wr_data_end;
               wr_data      = gnt_q ? m1_wr_data      : m0_wr_data;
               wr_data_mask = gnt_q ? m1_wr_data_mask : m0_wr_data_mask;
               if (gnt_q) m1_wr_data_rdy = wr_data_rdy;
               else       m0_wr_data_rdy = wr_data_rdy;
               if (wr_data_en && wr_data_rdy && wr_data_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
         // read returns are independent of the command FSM
         if (rd_data_valid) begin
            if (empty) begin
               err_d = 1'b1;
            end else begin
               if (head) begin
                  m1_rd_data_valid = 1'b1;
                  m1_rd_data_end   = rd_data_end;
               end else begin
                  m0_rd_data_valid = 1'b1;
                  m0_rd_data_end   = rd_data_end;
               end
               pop = rd_data_end;
            end
         end
      end
   end

   assign wp_d  = push ? nxt(wp_q) : wp_q;
   assign rp_d  = pop  ? nxt(rp_q) : rp_q;
   assign cnt_d = cnt_q + CW'(push) - CW'(pop);

   always_ff @(posedge dma_clk) begin
      if (ddr_rst) begin
         state_q <= S_IDLE;
         gnt_q   <= 1'b0;
`ifndef ARB_M0_PRIORITY_EN
         last_q  <= 1'b1;
`endif
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
`ifndef ARB_M0_PRIORITY_EN
         last_q  <= last_d;
`endif
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge dma_clk) begin
      if (push) own_q[wp_q] <= gnt_q;
   end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Randomized bench for ddr3_cmd_arbiter: transaction-level model of grant order and read ownership.
module tb_ddr3_cmd_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;
   localparam int MW = DW / 8;
   localparam int DEPTH = 4;

   logic dma_clk = 1'b0;
   logic ddr_rst, init_calib_complete;
   logic m0_cmd_en, m1_cmd_en, m0_cmd_ready, m1_cmd_ready;
   logic [2:0] m0_cmd, m1_cmd, cmd;
   logic [AW-1:0] m0_addr, m1_addr, addr;
   logic [5:0] m0_app_burst_number, m1_app_burst_number, app_burst_number;
   logic m0_wr_data_en, m0_wr_data_end, m1_wr_data_en, m1_wr_data_end;
   logic [DW-1:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data, rd_data, wr_data;
   logic [MW-1:0] m0_wr_data_mask, m1_wr_data_mask, wr_data_mask;
   logic m0_wr_data_rdy, m1_wr_data_rdy, m0_rd_data_valid, m1_rd_data_valid;
   logic m0_rd_data_end, m1_rd_data_end;
   logic cmd_ready, wr_data_rdy, rd_data_valid, rd_data_end;
   logic cmd_en, wr_data_en, wr_data_end, err_rd_orphan;

   int total = 0;
   int bad = 0;
   int last = 1;
   int q[$];

   ddr3_cmd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_FIFO_DEPTH(DEPTH)) dut (
      .dma_clk(dma_clk), .ddr_rst(ddr_rst), .init_calib_complete(init_calib_complete),
      .m0_cmd_en(m0_cmd_en), .m0_cmd(m0_cmd), .m0_addr(m0_addr),
      .m0_app_burst_number(m0_app_burst_number), .m0_cmd_ready(m0_cmd_ready),
      .m0_wr_data_en(m0_wr_data_en), .m0_wr_data_end(m0_wr_data_end), .m0_wr_data(m0_wr_data),
      .m0_wr_data_mask(m0_wr_data_mask), .m0_wr_data_rdy(m0_wr_data_rdy),
      .m0_rd_data_valid(m0_rd_data_valid), .m0_rd_data_end(m0_rd_data_end), .m0_rd_data(m0_rd_data),
      .m1_cmd_en(m1_cmd_en), .m1_cmd(m1_cmd), .m1_addr(m1_addr),
      .m1_app_burst_number(m1_app_burst_number), .m1_cmd_ready(m1_cmd_ready),
      .m1_wr_data_en(m1_wr_data_en), .m1_wr_data_end(m1_wr_data_end), .m1_wr_data(m1_wr_data),
      .m1_wr_data_mask(m1_wr_data_mask), .m1_wr_data_rdy(m1_wr_data_rdy),
      .m1_rd_data_valid(m1_rd_data_valid), .m1_rd_data_end(m1_rd_data_end), .m1_rd_data(m1_rd_data),
      .cmd_ready(cmd_ready), .wr_data_rdy(wr_data_rdy), .rd_data_valid(rd_data_valid),
      .rd_data_end(rd_data_end), .rd_data(rd_data), .cmd_en(cmd_en), .cmd(cmd), .addr(addr),
      .app_burst_number(app_burst_number), .wr_data_en(wr_data_en), .wr_data_end(wr_data_end),
      .wr_data(wr_data), .wr_data_mask(wr_data_mask), .err_rd_orphan(err_rd_orphan)
   );

   always #5 dma_clk = ~dma_clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // inputs change 2 time units after the rising edge, outputs are sampled 1 unit later
   task automatic cyc();
      @(posedge dma_clk);
      #2;
   endtask

   function automatic logic [DW-1:0] rnd_wide();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // reference arbitration rule: who should win given which requests are eligible
   function automatic int pick(input bit e0, input bit e1);
`ifdef ARB_M0_PRIORITY_EN
      return e0 ? 0 : 1;
`else
      if (e0 && e1) return (last == 1) ? 0 : 1;
      return e1 ? 1 : 0;
`endif
   endfunction

   task automatic set_req(input int m, input bit en, input bit rd, input logic [AW-1:0] a,
                          input logic [5:0] bn);
      if (m == 0) begin
         m0_cmd_en = en; m0_cmd = rd ? 3'b001 : 3'b000; m0_addr = a; m0_app_burst_number = bn;
      end else begin
         m1_cmd_en = en; m1_cmd = rd ? 3'b001 : 3'b000; m1_addr = a; m1_app_burst_number = bn;
      end
   endtask

   task automatic drive_wr(input int m, input bit en, input bit e, input logic [DW-1:0] d,
                           input logic [MW-1:0] mk);
      if (m == 0) begin
         m0_wr_data_en = en; m0_wr_data_end = e; m0_wr_data = d; m0_wr_data_mask = mk;
      end else begin
         m1_wr_data_en = en; m1_wr_data_end = e; m1_wr_data = d; m1_wr_data_mask = mk;
      end
   endtask

   // both masters present their requests; serve them all with random DDR-side stalls
   task automatic run_round(input bit p0, input bit rd0, input logic [AW-1:0] a0,
                            input bit p1, input bit rd1, input logic [AW-1:0] a1);
      bit pend[2];
      bit rd[2];
      logic [AW-1:0] ad[2];
      logic [5:0] bn[2];
      int first, it, w, nb, done_b, k;
      bit cr, rdy, we;
      logic [DW-1:0] wd;
      logic [MW-1:0] wm;
      pend[0] = p0; pend[1] = p1; rd[0] = rd0; rd[1] = rd1; ad[0] = a0; ad[1] = a1;
      bn[0] = 6'($urandom); bn[1] = 6'($urandom);
      set_req(0, p0, rd0, a0, bn[0]);
      set_req(1, p1, rd1, a1, bn[1]);
      rd_data_valid = 1'b0; rd_data_end = 1'b0; wr_data_rdy = 1'b0;
      first = -1; it = 0;
      while ((pend[0] || pend[1]) && it < 60) begin
         cr = 1'($urandom_range(0, 1));
         cmd_ready = cr;
         #1;
         if (cmd_en === 1'b1) begin
            w = pick(pend[0] && (!rd[0] || q.size() < DEPTH), pend[1] && (!rd[1] || q.size() < DEPTH));
            if (first < 0) begin
               first = it;
               chk("latency", 128'(first), 128'(1));
            end
            chk("cmd_addr", 128'(addr), 128'(ad[w]));
            chk("cmd_op", 128'(cmd), 128'(rd[w] ? 3'b001 : 3'b000));
            chk("cmd_burst", 128'(app_burst_number), 128'(bn[w]));
            chk("cmd_rdy0", 128'(m0_cmd_ready), 128'((w == 0) ? cr : 1'b0));
            chk("cmd_rdy1", 128'(m1_cmd_ready), 128'((w == 1) ? cr : 1'b0));
            cyc(); it++;
            if (cr) begin
               last = w;
               pend[w] = 1'b0;
               set_req(w, 1'b0, rd[w], ad[w], bn[w]);
               if (rd[w]) begin
                  q.push_back(w);
               end else begin
                  nb = $urandom_range(1, 2); done_b = 0; k = 0;
                  while (done_b < nb && k < 20) begin
                     wd = rnd_wide(); wm = MW'($urandom); we = (done_b == nb - 1);
                     drive_wr(w, 1'b1, we, wd, wm);
                     rdy = 1'($urandom_range(0, 1));
                     wr_data_rdy = rdy;
                     #1;
                     chk("wr_en", 128'(wr_data_en), 128'(1));
                     chk("wr_end", 128'(wr_data_end), 128'(we));
                     chk("wr_data", 128'(wr_data), 128'(wd));
                     chk("wr_mask", 128'(wr_data_mask), 128'(wm));
                     chk("wr_rdy0", 128'(m0_wr_data_rdy), 128'((w == 0) ? rdy : 1'b0));
                     chk("wr_rdy1", 128'(m1_wr_data_rdy), 128'((w == 1) ? rdy : 1'b0));
                     chk("wr_no_cmd", 128'(cmd_en), 128'(0));
                     cyc(); k++;
                     if (rdy) done_b++;
                  end
                  drive_wr(w, 1'b0, 1'b0, '0, '0);
                  wr_data_rdy = 1'b0;
                  chk("wr_beats", 128'(done_b), 128'(nb));
               end
            end
         end else begin
            cyc(); it++;
         end
      end
      chk("round_done", 128'(pend[0] | pend[1]), 128'(0));
   endtask

   // return one burst for the oldest outstanding read
   task automatic return_one();
      int nb, own;
      bit e;
      logic [DW-1:0] d;
      own = q[0];
      nb = $urandom_range(1, 2);
      for (int b = 0; b < nb; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            rd_data_valid = 1'b0; rd_data_end = 1'b0;
            #1;
            chk("rd_gap_v0", 128'(m0_rd_data_valid), 128'(0));
            chk("rd_gap_v1", 128'(m1_rd_data_valid), 128'(0));
            cyc();
         end
         e = (b == nb - 1); d = rnd_wide();
         rd_data = d; rd_data_valid = 1'b1; rd_data_end = e;
         #1;
         chk("rd_v0", 128'(m0_rd_data_valid), 128'(own == 0));
         chk("rd_v1", 128'(m1_rd_data_valid), 128'(own == 1));
         chk("rd_end0", 128'(m0_rd_data_end), 128'(e && own == 0));
         chk("rd_end1", 128'(m1_rd_data_end), 128'(e && own == 1));
         chk("rd_data0", 128'(m0_rd_data), 128'(d));
         chk("rd_data1", 128'(m1_rd_data), 128'(d));
         cyc();
      end
      own = q.pop_front();
      rd_data_valid = 1'b0; rd_data_end = 1'b0;
   endtask

   task automatic return_all();
      while (q.size() > 0) return_one();
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      bit p0, p1;
      ddr_rst = 1'b1; init_calib_complete = 1'b0;
      set_req(0, 1'b0, 1'b0, '0, '0); set_req(1, 1'b0, 1'b0, '0, '0);
      drive_wr(0, 1'b0, 1'b0, '0, '0); drive_wr(1, 1'b0, 1'b0, '0, '0);
      cmd_ready = 1'b0; wr_data_rdy = 1'b0; rd_data_valid = 1'b0; rd_data_end = 1'b0; rd_data = '0;
      #2;
      // everything quiet while reset is held, even with live inputs
      rd_data = rnd_wide(); rd_data_valid = 1'b1; rd_data_end = 1'b1;
      set_req(0, 1'b1, 1'b0, 28'h123, 6'd3); cmd_ready = 1'b1; wr_data_rdy = 1'b1;
      cyc(); cyc(); #1;
      chk("rst_cmd_en", 128'(cmd_en), 128'(0));
      chk("rst_m0_rdy", 128'(m0_cmd_ready), 128'(0));
      chk("rst_rd_data", 128'(m0_rd_data), 128'(0));
      chk("rst_rd_v0", 128'(m0_rd_data_valid), 128'(0));
      chk("rst_err", 128'(err_rd_orphan), 128'(0));
      chk("rst_wr_rdy", 128'(m0_wr_data_rdy), 128'(0));
      ddr_rst = 1'b0; rd_data_valid = 1'b0; rd_data_end = 1'b0;
      // no grant without calibration
      cyc(); #1;
      chk("nocal_cmd_en", 128'(cmd_en), 128'(0));
      cyc(); #1;
      chk("nocal_cmd_en2", 128'(cmd_en), 128'(0));
      chk("orphan_none", 128'(err_rd_orphan), 128'(0));
      set_req(0, 1'b0, 1'b0, '0, '0);
      init_calib_complete = 1'b1;
      cyc();

      // simultaneous writes after reset: m0 first, then m1
      run_round(1'b1, 1'b0, 28'h0AAA000, 1'b1, 1'b0, 28'h0BBB000);
      // m0 read then m1 read, bursts routed in order
      run_round(1'b1, 1'b1, 28'h0000100, 1'b0, 1'b0, '0);
      run_round(1'b0, 1'b0, '0, 1'b1, 1'b1, 28'h0000200);
      return_all();

      // calibration drops mid-transaction: finish it, then block
      set_req(0, 1'b1, 1'b0, 28'h0C0FFEE, 6'd1); cmd_ready = 1'b1;
      cyc();
      init_calib_complete = 1'b0;
      #1;
      chk("cal_cmd_en", 128'(cmd_en), 128'(1));
      chk("cal_m0_rdy", 128'(m0_cmd_ready), 128'(1));
      cyc();
      set_req(0, 1'b0, 1'b0, 28'h0C0FFEE, 6'd1);
      set_req(1, 1'b1, 1'b0, 28'h0D00D00, 6'd2);
      d = rnd_wide();
      drive_wr(0, 1'b1, 1'b1, d, '1); wr_data_rdy = 1'b1;
      #1;
      chk("cal_wr_en", 128'(wr_data_en), 128'(1));
      chk("cal_wr_data", 128'(wr_data), 128'(d));
      cyc();
      drive_wr(0, 1'b0, 1'b0, '0, '0); wr_data_rdy = 1'b0;
      last = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("cal_blk_cmd_en", 128'(cmd_en), 128'(0));
         chk("cal_blk_rdy1", 128'(m1_cmd_ready), 128'(0));
         cyc();
      end
      init_calib_complete = 1'b1;
      run_round(1'b0, 1'b0, '0, 1'b1, 1'b0, 28'h0D00D00);

      // owner FIFO fills with four m1 reads; fifth waits for a return
      for (int i = 0; i < 4; i++) run_round(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(32'h400 + i));
      set_req(1, 1'b1, 1'b1, 28'h0000555, 6'd0); cmd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("full_cmd_en", 128'(cmd_en), 128'(0));
         chk("full_rdy1", 128'(m1_cmd_ready), 128'(0));
         cyc();
      end
      return_one();
      run_round(1'b0, 1'b0, '0, 1'b1, 1'b1, 28'h0000555);
      return_all();

      // random mixes of reads and writes from both masters
      for (int r = 0; r < 30; r++) begin
         p0 = 1'($urandom_range(0, 1)); p1 = 1'($urandom_range(0, 1));
         if (!p0 && !p1) p0 = 1'b1;
         a = AW'($urandom);
         run_round(p0, 1'($urandom_range(0, 1)), a, p1, 1'($urandom_range(0, 1)), AW'($urandom));
         if (q.size() >= 2 || $urandom_range(0, 2) == 0) return_all();
      end
      return_all();

      // read data with nothing outstanding
      rd_data = rnd_wide(); rd_data_valid = 1'b1; rd_data_end = 1'b1;
      #1;
      chk("orph_v0", 128'(m0_rd_data_valid), 128'(0));
      chk("orph_v1", 128'(m1_rd_data_valid), 128'(0));
      chk("orph_end0", 128'(m0_rd_data_end), 128'(0));
      cyc();
      rd_data_valid = 1'b0; rd_data_end = 1'b0;
      #1;
      chk("orph_err", 128'(err_rd_orphan), 128'(1));
      cyc(); #1;
      chk("orph_sticky", 128'(err_rd_orphan), 128'(1));

      // reset in the middle of a write burst
      cyc();
      set_req(0, 1'b1, 1'b0, 28'h0E0E0E0, 6'd4); cmd_ready = 1'b1;
      cyc(); cyc();
      set_req(0, 1'b0, 1'b0, 28'h0E0E0E0, 6'd4);
      drive_wr(0, 1'b1, 1'b0, rnd_wide(), '1); wr_data_rdy = 1'b1;
      #1;
      chk("mid_wr_en", 128'(wr_data_en), 128'(1));
      ddr_rst = 1'b1;
      #1;
      chk("mid_rst_wr_en", 128'(wr_data_en), 128'(0));
      chk("mid_rst_rdy0", 128'(m0_wr_data_rdy), 128'(0));
      chk("mid_rst_err", 128'(err_rd_orphan), 128'(0));
      cyc();
      ddr_rst = 1'b0;
      #1;
      chk("post_rst_wr_en", 128'(wr_data_en), 128'(0));
      chk("post_rst_cmd_en", 128'(cmd_en), 128'(0));
      chk("post_rst_rdy0", 128'(m0_wr_data_rdy), 128'(0));
      chk("post_rst_err", 128'(err_rd_orphan), 128'(0));
      drive_wr(0, 1'b0, 1'b0, '0, '0); wr_data_rdy = 1'b0;
      last = 1;
      q.delete();
      cyc();
      // tie after reset goes to m0 again
      run_round(1'b1, 1'b1, 28'h0000700, 1'b1, 1'b1, 28'h0000800);
      return_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ddr3_cmd_arbiter.md
DDR3_CMD_ARBITER -- requirements
Module: ddr3_cmd_arbiter

Interface
- REQ-001: Parameter ADDR_WIDTH SHALL default to 28 and set the byte address width.
- REQ-002: Parameter DATA_WIDTH SHALL default to 128 and set the user data width; mask width is DATA_WIDTH/8.
- REQ-003: Parameter RD_FIFO_DEPTH SHALL default to 4 and set the maximum number of outstanding read commands; it is a power of two.
- REQ-004: dma_clk, input, 1: the single clock; all logic is clocked on its rising edge.
- REQ-005: ddr_rst, input, 1: synchronous, active-high reset.
- REQ-006: init_calib_complete, input, 1: DDR3 calibration done; no grant is issued while it is low.
- REQ-007: m0_cmd_en and m1_cmd_en, input, 1: per-master command request.
- REQ-008: m0_cmd and m1_cmd, input, 3: per-master command; 3'b000 is write and 3'b001 is read.
- REQ-009: m0_addr and m1_addr, input, ADDR_WIDTH; m0_app_burst_number and m1_app_burst_number, input, 6.
- REQ-010: m0_cmd_ready and m1_cmd_ready, output, 1: per-master command accept.
- REQ-011: m0_wr_data_en, m0_wr_data_end, m1_wr_data_en and m1_wr_data_end, input, 1 each.
- REQ-012: m0_wr_data and m1_wr_data, input, DATA_WIDTH; m0_wr_data_mask and m1_wr_data_mask, input, DATA_WIDTH/8.
- REQ-013: m0_wr_data_rdy, m1_wr_data_rdy, m0_rd_data_valid, m1_rd_data_valid, m0_rd_data_end and m1_rd_data_end, output, 1 each.
- REQ-014: m0_rd_data and m1_rd_data, output, DATA_WIDTH.
- REQ-015: The DDR3 user-side ports SHALL be cmd_ready, wr_data_rdy, rd_data_valid, rd_data_end and rd_data as inputs, and cmd_en, cmd, addr, app_burst_number, wr_data_en, wr_data_end, wr_data and wr_data_mask as outputs, with the same widths as the per-master ports.

Function
- REQ-016: The FSM SHALL have three states: IDLE, CMD and WDATA.
- REQ-017: IDLE: when init_calib_complete=1 and at least one mN_cmd_en=1 is eligible, the arbiter SHALL register the grant and move to CMD on the next cycle; otherwise it SHALL stay in IDLE.
- REQ-018: A read request SHALL be ineligible while the owner FIFO is full.
- REQ-019: Arbitration SHALL be round-robin. When both masters are eligible, the master not granted last wins; last_grant resets to 1, so m0 wins the first tie.
- REQ-020: CMD: cmd_en, cmd, addr and app_burst_number SHALL be driven combinationally from the granted master. cmd_ready SHALL be routed only to the granted master; the other master's mN_cmd_ready is 0.
- REQ-021: A master SHALL hold cmd_en, cmd, addr and app_burst_number stable until it sees cmd_ready=1.
- REQ-022: A command is accepted when cmd_en and cmd_ready are both 1. On accepting a write the FSM SHALL go to WDATA; on accepting a read it SHALL push the owner ID into the FIFO and return to IDLE.
- REQ-023: Command latency SHALL be 1 cycle from mN_cmd_en rising to cmd_en on the DDR3 side.
- REQ-024: WDATA: wr_data_en, wr_data_end, wr_data and wr_data_mask SHALL come from the granted master, and wr_data_rdy SHALL be routed to it only.
- REQ-025: A write beat completes when wr_data_en, wr_data_rdy and wr_data_end are all 1; the FSM SHALL then return to IDLE.
- REQ-026: Read return: rd_data SHALL be broadcast to both masters. rd_data_valid and rd_data_end SHALL be gated to the owner at the head of the FIFO; the FIFO pops on rd_data_valid with rd_data_end.
- REQ-027: A FIFO push and pop in the same cycle SHALL leave the count unchanged; the pointers wrap modulo RD_FIFO_DEPTH.
- REQ-028: If rd_data_valid arrives while the FIFO is empty, it SHALL be dropped and the sticky output err_rd_orphan (1 bit) SHALL be set; err_rd_orphan clears only on reset.
- REQ-029: If init_calib_complete falls in CMD or WDATA, the arbiter SHALL finish the current transaction first and then block further grants.
- REQ-030: Outputs not owned by a grant SHALL be driven to 0.

Reset
- REQ-031: When ddr_rst=1 on a clock edge, the arbiter SHALL enter IDLE, set last_grant to 1, empty the FIFO and clear err_rd_orphan.
- REQ-032: During reset all outputs SHALL be 0.
- REQ-033: A reset during CMD or WDATA SHALL abort the transaction without completing it.

Configuration
- REQ-034: With macro ARB_M0_PRIORITY_EN defined, m0 SHALL have strict priority whenever it is eligible, and last_grant is unused.
- REQ-035: Without ARB_M0_PRIORITY_EN, arbitration SHALL be round-robin per REQ-019.

Verification
- REQ-036: Both masters raise write requests in the same cycle after reset -> m0 is granted first (cmd_en=1 one cycle later, addr=m0_addr), then m1 is granted after m0's wr_data_end.
- REQ-037: With ARB_M0_PRIORITY_EN defined, m0 issues back-to-back writes while m1 requests -> m1_cmd_ready stays 0 until m0_cmd_en=0.
- REQ-038: m0 issues a read, then m1 issues a read; the DDR3 side returns two bursts -> the first burst asserts only m0_rd_data_valid and the second only m1_rd_data_valid.
- REQ-039: m1 issues 4 reads with no data returned -> a 5th m1 read is not granted (m1_cmd_ready=0); after one rd_data_end the 5th read is granted.
- REQ-040: A pulse of rd_data_valid=1 with no outstanding reads -> err_rd_orphan=1 and both mN_rd_data_valid=0.
- REQ-041: ddr_rst=1 is asserted mid-WDATA -> the next cycle the FSM is in IDLE, wr_data_en=0 and cmd_en=0.
